// File: rtl/aes_pkg.sv
// Shared AES constants, state encoding and byte-level GF(2^8) helpers.
// S-boxes are computed as inverse-then-affine so both cipher directions share one source.
package aes_pkg;
  localparam int NB = 128;
  localparam int NR = 10;

  typedef enum logic [2:0] {
    ST_NOKEY,
    ST_EXPAND,
    ST_READY,
    ST_DECRYPT,
    ST_HOLD
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gmul(gmul(a, a), a);
    x7   = gmul(gmul(x3, x3), a);
    x15  = gmul(gmul(x7, x7), a);
    x31  = gmul(gmul(x15, x15), a);
    x63  = gmul(gmul(x31, x31), a);
    x127 = gmul(gmul(x63, x63), a);
    return gmul(x127, x127);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return ginv(b);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One forward AES-128 key-schedule step: previous round key to the next one.
  function automatic logic [NB-1:0] key_step(input logic [NB-1:0] prev, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = prev[127:96];
    w1 = prev[95:64];
    w2 = prev[63:32];
    w3 = prev[31:0];
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction
endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless i_last. Byte 0 is the MSB; the state is column-major.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [NB-1:0] i_state,
  input  logic [NB-1:0] i_rk,
  input  logic          i_last,
  output logic [NB-1:0] o_state
);
  logic [NB-1:0] w_sb;
  logic [NB-1:0] w_ark;
  logic [NB-1:0] w_mix;
  logic [7:0]    w_a0, w_a1, w_a2, w_a3;

  always_comb begin
    w_sb  = '0;
    w_mix = '0;
    w_a0  = '0;
    w_a1  = '0;
    w_a2  = '0;
    w_a3  = '0;
    // Row r of output column c comes from column (c - r) mod 4 of the input
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sb[127-8*(4*c+r) -: 8] = inv_sbox(i_state[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
    w_ark = w_sb ^ i_rk;
    for (int c = 0; c < 4; c++) begin
      w_a0 = w_ark[127-32*c -: 8];
      w_a1 = w_ark[119-32*c -: 8];
      w_a2 = w_ark[111-32*c -: 8];
      w_a3 = w_ark[103-32*c -: 8];
      w_mix[127-32*c -: 8] = gmul(w_a0, 8'h0e) ^ gmul(w_a1, 8'h0b) ^ gmul(w_a2, 8'h0d) ^ gmul(w_a3, 8'h09);
      w_mix[119-32*c -: 8] = gmul(w_a0, 8'h09) ^ gmul(w_a1, 8'h0e) ^ gmul(w_a2, 8'h0b) ^ gmul(w_a3, 8'h0d);
      w_mix[111-32*c -: 8] = gmul(w_a0, 8'h0d) ^ gmul(w_a1, 8'h09) ^ gmul(w_a2, 8'h0e) ^ gmul(w_a3, 8'h0b);
      w_mix[103-32*c -: 8] = gmul(w_a0, 8'h0b) ^ gmul(w_a1, 8'h0d) ^ gmul(w_a2, 8'h09) ^ gmul(w_a3, 8'h0e);
    end
    o_state = i_last ? w_ark : w_mix;
  end
endmodule

// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 decryptor: 10-cycle key expansion, then one round per clock;
// output valid 10 cycles after input transfer, held until out_ready, no block overlap.
module aes128_inv_cipher_iter
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          key_load,
  input  logic [NB-1:0] cipher_key,
  output logic          key_ready,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NB-1:0] cipher_text,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NB-1:0] plain_text,
  output logic          busy
);
  state_e        r_st;
  state_e        w_st_nxt;
  logic [3:0]    r_cnt;
  logic [NB-1:0] r_rk [0:NR];
  logic [NB-1:0] r_state;
  logic [NB-1:0] r_pt;
  logic          r_key_ready;
  logic          r_out_valid;
  logic          w_key_go;
  logic          w_xfer;
  logic [NB-1:0] w_rk_next;
  logic [NB-1:0] w_round;

  assign w_rk_next  = key_step(r_rk[r_cnt - 4'd1], rcon(r_cnt));
  assign key_ready  = r_key_ready;
  assign out_valid  = r_out_valid;
  assign plain_text = r_pt;

  aes_inv_round u_round (
    .i_state (r_state),
    .i_rk    (r_rk[r_cnt]),
    .i_last  (r_cnt == 4'd0),
    .o_state (w_round)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_st <= ST_NOKEY;
    else        r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    in_ready = 1'b0;
    busy     = 1'b0;
    w_key_go = 1'b0;
    w_xfer   = 1'b0;
    case (r_st)
      ST_NOKEY: begin
        if (key_load) begin
          w_key_go = 1'b1;
          w_st_nxt = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        busy = 1'b1;
        if (r_cnt == 4'(NR)) w_st_nxt = ST_READY;
      end
      ST_READY: begin
        in_ready = 1'b1;
        // A new key wins over a waiting ciphertext
        if (key_load) begin
          w_key_go = 1'b1;
          w_st_nxt = ST_EXPAND;
        end else if (in_valid) begin
          w_xfer   = 1'b1;
          w_st_nxt = ST_DECRYPT;
        end
      end
      ST_DECRYPT: begin
        busy = 1'b1;
        if (r_cnt == 4'd0) w_st_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) w_st_nxt = ST_READY;
      end
      default: w_st_nxt = ST_NOKEY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_state     <= '0;
      r_pt        <= '0;
      r_key_ready <= 1'b0;
      r_out_valid <= 1'b0;
      for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
    end else if (w_key_go) begin
      r_rk[0]     <= cipher_key;
      r_cnt       <= 4'd1;
      r_key_ready <= 1'b0;
    end else begin
      case (r_st)
        ST_EXPAND: begin
          r_rk[r_cnt] <= w_rk_next;
          r_cnt       <= r_cnt + 4'd1;
          if (r_cnt == 4'(NR)) r_key_ready <= 1'b1;
        end
        ST_READY: begin
          if (w_xfer) begin
            r_state <= cipher_text ^ r_rk[NR];
            r_cnt   <= 4'(NR - 1);
          end
        end
        ST_DECRYPT: begin
          if (r_cnt == 4'd0) begin
            r_pt        <= w_round;
            r_out_valid <= 1'b1;
          end else begin
            r_state <= w_round;
            r_cnt   <= r_cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_inv_cipher_iter.sv
// Scoreboard bench for aes128_inv_cipher_iter using FIPS-197 App. B and C.1 vectors:
// stimulus pushes expected plaintexts, a negedge monitor pops them on each output handshake.
module tb_aes128_inv_cipher_iter;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_load;
  logic [127:0] cipher_key;
  logic         key_ready;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] cipher_text;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plain_text;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [127:0] exp_q[$];
  int pop_cyc[$];

  aes128_inv_cipher_iter dut (
    .clk         (clk),
    .reset       (reset),
    .key_load    (key_load),
    .cipher_key  (cipher_key),
    .key_ready   (key_ready),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cipher_text (cipher_text),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .plain_text  (plain_text),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none", plain_text);
      end else begin
        chk("plain_text", plain_text, exp_q.pop_front());
      end
      pop_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    int n;
    key_load   = 1'b1;
    cipher_key = k;
    tick();
    key_load = 1'b0;
    n = 0;
    while (!key_ready && n < 30) begin
      tick();
      n++;
    end
    chk("key_ready_latency", 128'(n), 128'd10);
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] pt, input bit push);
    int n;
    if (push) exp_q.push_back(pt);
    cipher_text = ct;
    in_valid    = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk(name, 128'(n), 128'd10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_rdy;
    int seen_vld;
    reset = 1'b0; key_load = 1'b0; cipher_key = '0;
    in_valid = 1'b0; cipher_text = '0; out_ready = 1'b1;
    tick(2);
    chk("rst_key_ready", 128'(key_ready), 128'd0);
    chk("rst_in_ready",  128'(in_ready),  128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy",      128'(busy),      128'd0);
    chk("rst_plain_text", plain_text, 128'd0);
    reset = 1'b1;
    tick();

    // Ciphertext offered before any key must be ignored
    in_valid = 1'b1; cipher_text = CT_B;
    tick(3);
    chk("nokey_in_ready", 128'(in_ready), 128'd0);
    chk("nokey_busy", 128'(busy), 128'd0);
    in_valid = 1'b0;

    // App. B
    load_key(KEY_B);
    chk("rk10_appB", dut.r_rk[10], RK10_B);
    send(CT_B, PT_B, 1'b1);
    wait_out("latency_appB");
    tick();

    // App. C.1 with 5 cycles of backpressure, next block queued during HOLD
    load_key(KEY_C);
    out_ready = 1'b0;
    send(CT_C, PT_C, 1'b1);
    wait_out("latency_appC");
    exp_q.push_back(PT_C);
    in_valid = 1'b1; cipher_text = CT_C;
    for (int i = 0; i < 5; i++) begin
      chk("hold_plain_text", plain_text, PT_C);
      chk("hold_in_ready", 128'(in_ready), 128'd0);
      chk("hold_out_valid", 128'(out_valid), 128'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("release_in_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    chk("release_accept_busy", 128'(busy), 128'd1);
    chk("release_accept_in_ready", 128'(in_ready), 128'd0);
    wait_out("latency_after_release");
    tick(2);

    // Back-to-back blocks
    pop_cyc.delete();
    send(CT_C, PT_C, 1'b1);
    send(CT_C, PT_C, 1'b1);
    for (int i = 0; i < 60 && pop_cyc.size() < 2; i++) tick();
    if (pop_cyc.size() >= 2) chk("b2b_spacing", 128'(pop_cyc[1] - pop_cyc[0]), 128'd12);
    else chk("b2b_outputs", 128'(pop_cyc.size()), 128'd2);
    tick(2);

    // Rekey from READY: B then C.1
    load_key(KEY_B);
    send(CT_B, PT_B, 1'b1);
    wait_out("latency_rekey_B");
    tick();
    load_key(KEY_C);
    send(CT_C, PT_C, 1'b1);
    wait_out("latency_rekey_C");
    tick();

    // key_load during DECRYPT is ignored
    send(CT_C, PT_C, 1'b1);
    tick(3);
    key_load = 1'b1; cipher_key = KEY_B;
    tick();
    key_load = 1'b0;
    chk("decrypt_keyload_key_ready", 128'(key_ready), 128'd1);
    chk("decrypt_keyload_busy", 128'(busy), 128'd1);
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    tick();
    send(CT_C, PT_C, 1'b1);
    wait_out("latency_after_ignored_key");
    tick();

    // Reset during DECRYPT
    send(CT_C, PT_C, 1'b0);
    tick(4);
    reset = 1'b0;
    #1;
    chk("midrst_key_ready", 128'(key_ready), 128'd0);
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_plain_text", plain_text, 128'd0);
    chk("midrst_rk10", dut.r_rk[10], 128'd0);
    tick();
    reset = 1'b1;
    in_valid = 1'b1; cipher_text = CT_C;
    seen_rdy = 0; seen_vld = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (in_ready) seen_rdy++;
      if (out_valid) seen_vld++;
    end
    in_valid = 1'b0;
    chk("postrst_in_ready_cycles", 128'(seen_rdy), 128'd0);
    chk("postrst_out_valid_cycles", 128'(seen_vld), 128'd0);
    load_key(KEY_C);
    send(CT_C, PT_C, 1'b1);
    wait_out("latency_post_reset");
    tick(3);

    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aes128_inv_cipher_iter.md
Name: aes128_inv_cipher_iter

Overview:
- Iterative AES-128 inverse cipher (FIPS-197 InvCipher). It is the decrypt counterpart of the team's AES-128 encryption datapath.
- A key-load phase expands the cipher key forward into 11 stored round keys.
- Each ciphertext block is then decrypted at one round per clock, from round key 10 down to round key 0.
- The block sits between the block-cipher front end and the plaintext consumer, with valid/ready handshakes on both sides.

Parameters:
- NB, 128, block and key width in bits.
- NR, 10, number of cipher rounds (fixed for AES-128; no other value is supported).

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- key_load  in  1  one-cycle pulse; captures cipher_key and starts key expansion.
- cipher_key  in  128  AES-128 cipher key, MSB = byte 0.
- key_ready  out  1  high when all 11 round keys are valid.
- in_valid  in  1  ciphertext block valid.
- in_ready  out  1  block can accept a ciphertext.
- cipher_text  in  128  ciphertext input.
- out_valid  out  1  plain_text holds a decrypted block.
- out_ready  in  1  consumer accepts plain_text.
- plain_text  out  128  decrypted output.
- busy  out  1  high in EXPAND or DECRYPT.

Behaviour:
- Reset values: key_ready=0, in_ready=0, out_valid=0, busy=0, plain_text=0. State=NOKEY, round keys=0, round counter=0.
- States: NOKEY, EXPAND, READY, DECRYPT, HOLD.
- NOKEY → EXPAND: on key_load=1.
  - rk[0] ← cipher_key, counter ← 1.
- EXPAND: one round key per cycle, rk[i] = f(rk[i-1], rcon[i]) for i = 1..10.
  - After rk[10] is written: key_ready=1 and state → READY. EXPAND takes exactly 10 cycles.
- READY: in_ready=1.
  - in_valid=1 (transfer): state ← cipher_text ^ rk[10], counter ← 9, go to DECRYPT.
  - key_load=1 takes priority over in_valid: no transfer, key_ready drops, go to EXPAND.
- DECRYPT: in_ready=0.
  - Counter values 9..1: state ← InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[c])), then counter decrements.
  - Counter value 0: plain_text ← InvSubBytes(InvShiftRows(state)) ^ rk[0], out_valid=1, go to HOLD.
- Latency: the input transfer occurs at edge T. out_valid=1 after edge T+10.
- HOLD: plain_text and out_valid stay stable until out_ready=1.
  - On that edge: out_valid=0 and go to READY.
  - in_ready stays 0 in HOLD, so there is no overlap between blocks.
- key_load during DECRYPT or HOLD is ignored; the key can only be replaced from READY or NOKEY.
- key_load in NOKEY or READY while already in EXPAND is ignored until EXPAND completes.
- in_valid while key_ready=0 is not accepted.
- Reset asserted mid-EXPAND or mid-DECRYPT:
  - Everything returns to reset values and round keys are cleared.
  - A new key_load is required after reset deasserts.
- All byte operations use GF(2^8) with polynomial 0x11B. InvMixColumns coefficients are 0e, 0b, 0d, 09.

Decomposition:
- Shared package aes_pkg holds:
  - NB/NR constants;
  - S-box and inverse S-box ROM functions;
  - rcon table (01,02,04,08,10,20,40,80,1b,36);
  - xtime/gmul functions.
  - The encryptor must also use this package, so both directions share one S-box source.
- Sub-module aes_inv_round: purely combinational. Inputs are state, round key, and a last flag; output is the next state. Instantiated once and reused every cycle.
- Key expansion is inline (one step function from the package).

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, then ct 3925841d02dc09fbdc118597196a0b32 → pt 3243f6a8885a308d313198a2e0370734. key_ready rises exactly 10 cycles after key_load. Internal rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a → pt 00112233445566778899aabbccddeeff. out_valid exactly 10 cycles after the input transfer.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. plain_text stays stable, in_ready=0 throughout. Release → next block accepted the following cycle.
- Back-to-back: two App. C.1 ciphertexts with out_ready=1 → two correct outputs, 12 cycles apart (10 rounds + HOLD + READY).
- Rekey: load the App. B key, decrypt, key_load the App. C.1 key from READY, decrypt 69c4...c55a → correct pt. Also check key_load during DECRYPT is ignored (current block still decrypts correctly).
- Reset: assert reset=0 at cycle 5 of DECRYPT → outputs zero immediately. After release, in_valid is not accepted until a new key_load completes.
